// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: filters and deserializes device frames and folds
// scan-code set 2 prefixes into toggle-handshake ps2_key events.
module ps2_key_encoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 96000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_s;
  logic          dat_s;
  logic [FW-1:0] flt_cnt;
  logic          clk_flt;
  logic          clk_flt_d;
  logic          fall;

  logic [3:0]    bit_cnt;
  logic [9:0]    sr;
  logic [TW-1:0] to_cnt;
  logic          stop_ev;
  logic          frame_ok;
  logic [7:0]    rx_byte;
  logic          ign_code;

  logic          ext;
  logic          rel;
  logic [2:0]    skip;
  logic          ext_n;
  logic          rel_n;
  logic [2:0]    skip_n;
  logic [10:0]   key_n;
  logic          err_n;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_data_in};
    end
  end

  // Level must persist FILTER_LEN samples before the filtered clock moves
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      flt_cnt   <= '0;
      clk_flt   <= 1'b1;
      clk_flt_d <= 1'b1;
    end else begin
      clk_flt_d <= clk_flt;
      if (clk_s != clk_flt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_flt <= clk_s;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fall = clk_flt_d & ~clk_flt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt <= '0;
      sr      <= '0;
      to_cnt  <= '0;
    end else if (fall) begin
      to_cnt <= '0;
      if (bit_cnt == 4'd10) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        sr      <= {dat_s, sr[9:1]};
      end
    end else if (bit_cnt != 4'd0) begin
      if (to_cnt == TW'(TIMEOUT - 1)) begin
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // sr[0] start, sr[8:1] data, sr[9] parity; stop bit is live on dat_s
  assign stop_ev  = fall && (bit_cnt == 4'd10);
  assign frame_ok = ~sr[0] & dat_s & (^sr[9:1]);
  assign rx_byte  = sr[8:1];
  assign ign_code = (rx_byte == 8'hAA) || (rx_byte == 8'hFA) ||
                    (rx_byte == 8'hEE) || (rx_byte == 8'hFE);

  always_comb begin
    ext_n  = ext;
    rel_n  = rel;
    skip_n = skip;
    key_n  = ps2_key;
    err_n  = 1'b0;
    if (stop_ev) begin
      if (!frame_ok) begin
        err_n = 1'b1;
        ext_n = 1'b0;
        rel_n = 1'b0;
      end else if (skip != 3'd0) begin
        skip_n = skip - 3'd1;
      end else begin
        unique case (1'b1)
          (rx_byte == 8'hE1): begin
            skip_n = 3'd7;
            ext_n  = 1'b0;
            rel_n  = 1'b0;
          end
          (rx_byte == 8'hE0): ext_n = 1'b1;
          (rx_byte == 8'hF0): rel_n = 1'b1;
          (ign_code && !(ext || rel)): ;
          default: begin
            key_n = {~ps2_key[10], ~rel, ext, rx_byte};
            ext_n = 1'b0;
            rel_n = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_key   <= '0;
      frame_err <= 1'b0;
      ext       <= 1'b0;
      rel       <= 1'b0;
      skip      <= '0;
    end else begin
      ps2_key   <= key_n;
      frame_err <= err_n;
      ext       <= ext_n;
      rel       <= rel_n;
      skip      <= skip_n;
    end
  end

endmodule
